// File: rtl/stk_pipe_lk.sv
`default_nettype none
// ============================================================================
// stk_pipe_lk : per-engine linked-list stack lookup stage (PUSH / POP / INV)
// Rev 1.0
// ============================================================================

package stk_pkg;
  typedef enum logic [1:0] {
    OP_PUSH = 2'd0,
    OP_POP  = 2'd1,
    OP_INV  = 2'd2
  } opcode_t;
endpackage

module stk_pipe_lk #(
  parameter int ENGS_N = 4,
  parameter int PTR_W  = 5,
  parameter int DAT_W  = 128,
  localparam int ENGID_W = (ENGS_N > 1) ? $clog2(ENGS_N) : 1
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 i_lk_vld,
  input  logic [ENGID_W-1:0]   i_lk_engid,
  input  stk_pkg::opcode_t     i_lk_opcode,
  input  logic                 i_lk_dat_vld,
  input  logic [DAT_W-1:0]     i_lk_dat,
  input  logic [PTR_W-1:0]     i_al_ptr,
  output logic                 o_fr_vld,
  output logic [PTR_W-1:0]     o_fr_ptr,
  output logic                 o_busy,
  output logic                 o_wr_en,
  output logic [PTR_W-1:0]     o_wr_addr,
  output logic [DAT_W-1:0]     o_wr_dat,
  output logic                 o_rd_en,
  output logic [PTR_W-1:0]     o_rd_addr,
  input  logic [DAT_W-1:0]     i_rd_dat,
  output logic [ENGS_N-1:0]    o_rsp_vld,
  output logic                 o_rsp_err,
  output logic [DAT_W-1:0]     o_rsp_dat
);
  import stk_pkg::*;

  localparam int             c_NODES    = 1 << PTR_W;
  localparam int             c_SLOTS    = 1 << ENGID_W;
  localparam logic [PTR_W:0] c_CNT_FULL = (PTR_W+1)'(c_NODES);
  localparam logic [PTR_W:0] c_CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_WALK = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [PTR_W-1:0]    head_q  [c_SLOTS];
  logic [PTR_W-1:0]    head_d  [c_SLOTS];
  logic [PTR_W:0]      count_q [c_SLOTS];
  logic [PTR_W:0]      count_d [c_SLOTS];
  logic [PTR_W-1:0]    link_q  [c_NODES];
  logic [PTR_W-1:0]    cur_q, cur_d;
  logic [PTR_W-1:0]    left_q, left_d;
  logic [ENGID_W-1:0]  walk_eng_q, walk_eng_d;

  logic                p1_vld_q, p1_vld_d;
  logic [ENGID_W-1:0]  p1_eng_q, p1_eng_d;
  logic                p1_err_q, p1_err_d;
  logic                p1_pop_q, p1_pop_d;

  logic                fr_vld_q, fr_vld_d;
  logic [PTR_W-1:0]    fr_ptr_q, fr_ptr_d;
  logic                busy_q, busy_d;
  logic                wr_en_q, wr_en_d;
  logic [PTR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [DAT_W-1:0]    wr_dat_q, wr_dat_d;
  logic                rd_en_q, rd_en_d;
  logic [PTR_W-1:0]    rd_addr_q, rd_addr_d;
  logic [ENGS_N-1:0]   rsp_vld_q, rsp_vld_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_pop_q, rsp_pop_d;

  logic                w_acc;
  logic [PTR_W-1:0]    w_head;
  logic [PTR_W:0]      w_cnt;
  logic                w_lnk_we;
  logic [PTR_W-1:0]    w_lnk_addr;
  logic [PTR_W-1:0]    w_lnk_dat;

  function automatic logic [ENGS_N-1:0] onehot(input logic [ENGID_W-1:0] e);
    onehot = ENGS_N'(1) << e;
  endfunction

  always_comb begin
    w_acc      = i_lk_vld && !busy_q;
    w_head     = head_q[i_lk_engid];
    w_cnt      = count_q[i_lk_engid];
    w_lnk_we   = 1'b0;
    w_lnk_addr = i_al_ptr;
    w_lnk_dat  = w_head;

    state_d    = state_q;
    head_d     = head_q;
    count_d    = count_q;
    cur_d      = cur_q;
    left_d     = left_q;
    walk_eng_d = walk_eng_q;
    busy_d     = busy_q;

    p1_vld_d   = 1'b0;
    p1_eng_d   = i_lk_engid;
    p1_err_d   = 1'b0;
    p1_pop_d   = 1'b0;

    fr_vld_d   = 1'b0;
    fr_ptr_d   = fr_ptr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_dat_d   = wr_dat_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;

    rsp_vld_d  = p1_vld_q ? onehot(p1_eng_q) : '0;
    rsp_err_d  = p1_vld_q && p1_err_q;
    rsp_pop_d  = p1_vld_q && p1_pop_q;

    if (w_acc) begin
      unique case (i_lk_opcode)
        OP_PUSH: begin
          w_lnk_we             = 1'b1;
          head_d[i_lk_engid]   = i_al_ptr;
          if (w_cnt != c_CNT_FULL) count_d[i_lk_engid] = w_cnt + c_CNT_ONE;
          wr_en_d   = 1'b1;
          wr_addr_d = i_al_ptr;
          wr_dat_d  = i_lk_dat;
          p1_vld_d  = 1'b1;
        end
        OP_POP: begin
          p1_vld_d = 1'b1;
          if (w_cnt == '0) begin
            p1_err_d = 1'b1;
          end else begin
            head_d[i_lk_engid]  = link_q[w_head];
            count_d[i_lk_engid] = w_cnt - c_CNT_ONE;
            rd_en_d   = 1'b1;
            rd_addr_d = w_head;
            fr_vld_d  = 1'b1;
            fr_ptr_d  = w_head;
            p1_pop_d  = 1'b1;
          end
        end
        OP_INV: begin
          if (w_cnt == '0) begin
            p1_vld_d = 1'b1;
          end else begin
            // First node is freed straight from the accept cycle; the walk
            // then emits the remaining count-1 nodes.
            state_d    = c_ST_WALK;
            busy_d     = 1'b1;
            walk_eng_d = i_lk_engid;
            fr_vld_d   = 1'b1;
            fr_ptr_d   = w_head;
            cur_d      = link_q[w_head];
            left_d     = PTR_W'(w_cnt - c_CNT_ONE);
          end
        end
        default: ;
      endcase
    end

    unique case (state_q)
      c_ST_WALK: begin
        count_d[walk_eng_q] = count_q[walk_eng_q] - c_CNT_ONE;
        if (left_q != '0) begin
          fr_vld_d = 1'b1;
          fr_ptr_d = cur_q;
          cur_d    = link_q[cur_q];
          left_d   = left_q - c_PTR_ONE;
        end else begin
          state_d             = c_ST_DONE;
          rsp_vld_d           = onehot(walk_eng_q);
          head_d[walk_eng_q]  = '0;
          count_d[walk_eng_q] = '0;
        end
      end
      c_ST_DONE: begin
        state_d = c_ST_IDLE;
        busy_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= c_ST_IDLE;
      for (int i = 0; i < c_SLOTS; i++) begin
        head_q[i]  <= '0;
        count_q[i] <= '0;
      end
      cur_q      <= '0;
      left_q     <= '0;
      walk_eng_q <= '0;
      p1_vld_q   <= 1'b0;
      p1_eng_q   <= '0;
      p1_err_q   <= 1'b0;
      p1_pop_q   <= 1'b0;
      fr_vld_q   <= 1'b0;
      fr_ptr_q   <= '0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_dat_q   <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      rsp_vld_q  <= '0;
      rsp_err_q  <= 1'b0;
      rsp_pop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      count_q    <= count_d;
      cur_q      <= cur_d;
      left_q     <= left_d;
      walk_eng_q <= walk_eng_d;
      p1_vld_q   <= p1_vld_d;
      p1_eng_q   <= p1_eng_d;
      p1_err_q   <= p1_err_d;
      p1_pop_q   <= p1_pop_d;
      fr_vld_q   <= fr_vld_d;
      fr_ptr_q   <= fr_ptr_d;
      busy_q     <= busy_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_dat_q   <= wr_dat_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_err_q  <= rsp_err_d;
      rsp_pop_q  <= rsp_pop_d;
    end
  end

  // Link table holds only live list structure, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_lnk_we) link_q[w_lnk_addr] <= w_lnk_dat;
  end

  assign o_fr_vld  = fr_vld_q;
  assign o_fr_ptr  = fr_ptr_q;
  assign o_busy    = busy_q;
  assign o_wr_en   = wr_en_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_dat  = wr_dat_q;
  assign o_rd_en   = rd_en_q;
  assign o_rd_addr = rd_addr_q;
  assign o_rsp_vld = rsp_vld_q;
  assign o_rsp_err = rsp_err_q;
  assign o_rsp_dat = rsp_pop_q ? i_rd_dat : '0;

  a_no_vld_when_busy: assert property (@(posedge clk) disable iff (!arst_n)
    !(i_lk_vld && busy_q));
  a_push_not_full: assert property (@(posedge clk) disable iff (!arst_n)
    (w_acc && i_lk_opcode == OP_PUSH) |-> (w_cnt != c_CNT_FULL));
  a_push_dat_vld: assert property (@(posedge clk) disable iff (!arst_n)
    (w_acc && i_lk_opcode == OP_PUSH) |-> i_lk_dat_vld);

endmodule
`default_nettype wire
